// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for the nested loop-index generator.
//   state_e  - run-control FSM encoding (IDLE, RUN, DONE)
//   is_final - "count + step would pass end" test, evaluated one bit wider
//              than the operands so the sum can never wrap.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Widest index supported by is_final; callers zero-extend into it.
    localparam int unsigned MaxBits = 32;

    function automatic logic is_final(input logic [MaxBits-1:0] count,
                                      input logic [MaxBits-1:0] step,
                                      input logic [MaxBits-1:0] end_val);
        logic [MaxBits:0] sum;
        sum = {1'b0, count} + {1'b0, step};
        return sum > {1'b0, end_val};
    endfunction

endpackage

// File: rtl/counter_dim.sv
// counter_dim: one dimension of the nested counter.
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   load_i         - latch start/end/step and set the index to start
//   step_en_i      - advance this dimension (carry from the inner dims)
//   start_val_i, end_val_i, step_val_i - configuration, used only on load_i
//   count_o        - current index
//   final_o        - index is at its last value for the latched range
module counter_dim
    import counter_pkg::*;
#(
    parameter int unsigned Bits = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            step_en_i,
    input  logic [Bits-1:0] start_val_i,
    input  logic [Bits-1:0] end_val_i,
    input  logic [Bits-1:0] step_val_i,
    output logic [Bits-1:0] count_o,
    output logic            final_o
);

    logic [Bits-1:0] count_q, count_d;
    logic [Bits-1:0] start_q, end_q, step_q;
    logic            reload;

    always_comb begin
        // A zero step can never progress, so treat it as final. start > end
        // falls out of is_final naturally and keeps the index pinned at start.
        final_o = (step_q == '0) ||
                  is_final(MaxBits'(count_q), MaxBits'(step_q), MaxBits'(end_q));
        reload  = step_en_i && final_o;
        count_d = count_q;
        if (load_i) begin
            count_d = start_val_i;
        end else if (reload) begin
            count_d = start_q;
        end else if (step_en_i) begin
            count_d = count_q + step_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            start_q <= '0;
            end_q   <= '0;
            step_q  <= '0;
        end else begin
            count_q <= count_d;
            if (load_i) begin
                start_q <= start_val_i;
                end_q   <= end_val_i;
                step_q  <= step_val_i;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/nested_counter.sv
// nested_counter: multi-dimensional loop-index generator with ready/valid
// output. Dimension 0 is innermost; carries ripple outward.
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   start_i        - latch config and begin a run (IDLE only)
//   clear_i        - abort, return to IDLE (highest priority)
//   continuous_i   - with start_i: 1 = wrap forever, 0 = one-shot
//   start_vals_i / end_vals_i / step_vals_i - per-dimension config, packed
//                    with dimension d at [d*Bits +: Bits]
//   ready_i        - consumer accepts the current tuple
//   valid_o        - count_o holds a valid tuple
//   count_o        - current index tuple, same packing as the config
//   last_o         - bit d: dimensions 0..d all at their final value
//   busy_o         - run in progress
//   done_o         - one-cycle pulse after a one-shot run completes
module nested_counter
    import counter_pkg::*;
#(
    parameter int unsigned Bits = 8,
    parameter int unsigned Dims = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic                 continuous_i,
    input  logic [Dims*Bits-1:0] start_vals_i,
    input  logic [Dims*Bits-1:0] end_vals_i,
    input  logic [Dims*Bits-1:0] step_vals_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [Dims*Bits-1:0] count_o,
    output logic [Dims-1:0]      last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_e          state_q, state_d;
    logic            cont_q;
    logic            load;
    logic            accept;
    logic [Dims-1:0] final_w;
    logic [Dims-1:0] chain;
    logic [Dims-1:0] step_en;

    assign load   = (state_q == IDLE) && start_i && !clear_i;
    assign accept = (state_q == RUN) && ready_i && !clear_i;

    // chain[d]: dims 0..d are all final. Dim d steps when chain[d-1] holds.
    always_comb begin
        chain      = '0;
        step_en    = '0;
        chain[0]   = final_w[0];
        step_en[0] = accept;
        for (int unsigned d = 1; d < Dims; d++) begin
            chain[d]   = chain[d-1] & final_w[d];
            step_en[d] = accept & chain[d-1];
        end
    end

    for (genvar g = 0; g < Dims; g++) begin : g_dim
        counter_dim #(
            .Bits(Bits)
        ) u_dim (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load_i     (load),
            .step_en_i  (step_en[g]),
            .start_val_i(start_vals_i[g*Bits +: Bits]),
            .end_val_i  (end_vals_i[g*Bits +: Bits]),
            .step_val_i (step_vals_i[g*Bits +: Bits]),
            .count_o    (count_o[g*Bits +: Bits]),
            .final_o    (final_w[g])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (accept && chain[Dims-1] && !cont_q) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) cont_q <= continuous_i;
        end
    end

    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    // Outside RUN the index registers are stale, so last_o is masked.
    assign last_o  = valid_o ? chain : '0;

endmodule

// File: tb/tb_nested_counter.sv
module tb_nested_counter;

    localparam int unsigned Bits = 8;
    localparam int unsigned Dims = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 start_i;
    logic                 clear_i;
    logic                 continuous_i;
    logic [Dims*Bits-1:0] start_vals_i;
    logic [Dims*Bits-1:0] end_vals_i;
    logic [Dims*Bits-1:0] step_vals_i;
    logic                 ready_i;
    logic                 valid_o;
    logic [Dims*Bits-1:0] count_o;
    logic [Dims-1:0]      last_o;
    logic                 busy_o;
    logic                 done_o;

    nested_counter #(
        .Bits(Bits),
        .Dims(Dims)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .continuous_i(continuous_i),
        .start_vals_i(start_vals_i),
        .end_vals_i  (end_vals_i),
        .step_vals_i (step_vals_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .count_o     (count_o),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int   s0, e0, t0;
        int   s1, e1, t1;
        bit   cont;
        int   rmode;  // 0: ready always 1; 1: ready pattern 1,0,0,1
    } vec_t;

    typedef struct {
        logic [Bits-1:0] c0, c1;
        logic [1:0]      last;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic void gen_list(input int s, input int e, input int t, output int l[$]);
        int x;
        l = {};
        l.push_back(s);
        if (t != 0 && s <= e) begin
            x = s + t;
            while (x <= e) begin
                l.push_back(x);
                x += t;
            end
        end
    endfunction

    task automatic build(input vec_t v);
        int   l0[$];
        int   l1[$];
        int   reps;
        exp_t e;
        gen_list(v.s0, v.e0, v.t0, l0);
        gen_list(v.s1, v.e1, v.t1, l1);
        reps = v.cont ? 2 : 1;
        exp_q = {};
        for (int r = 0; r < reps; r++)
            for (int i1 = 0; i1 < l1.size(); i1++)
                for (int i0 = 0; i0 < l0.size(); i0++) begin
                    e.c0      = Bits'(l0[i0]);
                    e.c1      = Bits'(l1[i1]);
                    e.last[0] = (i0 == l0.size() - 1);
                    e.last[1] = e.last[0] && (i1 == l1.size() - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic drive_start(input vec_t v);
        start_vals_i = {Bits'(v.s1), Bits'(v.s0)};
        end_vals_i   = {Bits'(v.e1), Bits'(v.e0)};
        step_vals_i  = {Bits'(v.t1), Bits'(v.t0)};
        continuous_i = v.cont;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        // Scramble the config: a run must use the latched values only.
        start_vals_i = 16'($urandom);
        end_vals_i   = 16'($urandom);
        step_vals_i  = 16'($urandom);
        continuous_i = ~v.cont;
    endtask

    // Accept tuples against the scoreboard; stop_after < 0 drains it fully.
    task automatic run_tuples(input vec_t v, input int stop_after);
        int              budget = 0;
        int              got    = 0;
        bit              stalled = 0;
        logic [Dims*Bits-1:0] held = '0;
        bit              rdy;
        bit              patt[4] = '{1, 0, 0, 1};
        exp_t            e;
        while (exp_q.size() > 0 && budget < 2000 && (stop_after < 0 || got < stop_after)) begin
            rdy = (v.rmode == 1) ? patt[budget % 4] : 1'b1;
            ready_i = rdy;
            if (v.rmode == 1) start_i = 1'b1;  // ignored while RUN
            chk("valid_in_run", valid_o, 1);
            if (stalled) chk("stall_hold", count_o, held);
            if (v.cont) chk("no_done_cont", done_o, 0);
            if (valid_o && rdy) begin
                e = exp_q.pop_front();
                chk("count", count_o, {e.c1, e.c0});
                chk("last", last_o, e.last);
                got++;
            end
            stalled = valid_o && !rdy;
            held    = count_o;
            tick();
            budget++;
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        if (budget >= 2000) chk("run_timeout", 1, 0);
    endtask

    vec_t tbl[5];

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0; continuous_i = 1'b0;
        start_vals_i = '0; end_vals_i = '0; step_vals_i = '0; ready_i = 1'b1;

        tbl[0] = '{s0: 0, e0: 3,  t0: 1, s1: 0, e1: 2, t1: 1, cont: 0, rmode: 0};
        tbl[1] = '{s0: 2, e0: 13, t0: 3, s1: 0, e1: 1, t1: 1, cont: 0, rmode: 0};
        tbl[2] = '{s0: 0, e0: 1,  t0: 1, s1: 0, e1: 1, t1: 1, cont: 1, rmode: 0};
        tbl[3] = '{s0: 1, e0: 3,  t0: 1, s1: 4, e1: 6, t1: 2, cont: 0, rmode: 1};
        tbl[4] = '{s0: 5, e0: 7,  t0: 0, s1: 9, e1: 4, t1: 1, cont: 0, rmode: 0};

        tick(); tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_busy",  busy_o,  0);
        chk("rst_done",  done_o,  0);
        chk("rst_last",  last_o,  0);
        chk("rst_count", count_o, 0);
        rst_ni = 1'b1;
        tick();
        chk("idle_valid", valid_o, 0);

        for (int i = 0; i < 5; i++) begin
            build(tbl[i]);
            drive_start(tbl[i]);
            chk("busy_after_start", busy_o, 1);
            run_tuples(tbl[i], -1);
            if (tbl[i].cont) begin
                clear_i = 1'b1;
                tick();
                clear_i = 1'b0;
                chk("cont_clear_valid", valid_o, 0);
                chk("cont_clear_busy",  busy_o,  0);
            end else begin
                chk("done_pulse", done_o,  1);
                chk("done_valid", valid_o, 0);
                chk("done_busy",  busy_o,  0);
                tick();
                chk("done_gone",  done_o,  0);
                chk("idle_busy",  busy_o,  0);
                chk("idle_valid", valid_o, 0);
            end
        end

        // clear_i mid-run at tuple 5, with ready high in the same cycle.
        build(tbl[3]);
        tbl[3].rmode = 0;
        drive_start(tbl[3]);
        run_tuples(tbl[3], 5);
        clear_i = 1'b1;
        start_i = 1'b1;
        tick();
        clear_i = 1'b0;
        start_i = 1'b0;
        chk("clr_valid", valid_o, 0);
        chk("clr_busy",  busy_o,  0);
        tick();
        chk("clr_still_idle", busy_o, 0);
        build(tbl[3]);
        drive_start(tbl[3]);
        chk("clr_restart", count_o, {8'd4, 8'd1});
        run_tuples(tbl[3], -1);
        chk("clr_run_done", done_o, 1);
        tick();

        // Reset mid-run.
        build(tbl[0]);
        drive_start(tbl[0]);
        run_tuples(tbl[0], 3);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("mrst_valid", valid_o, 0);
        chk("mrst_busy",  busy_o,  0);
        chk("mrst_count", count_o, 0);
        chk("mrst_last",  last_o,  0);
        build(tbl[1]);
        drive_start(tbl[1]);
        chk("mrst_restart", count_o, {8'd0, 8'd2});
        run_tuples(tbl[1], -1);
        chk("mrst_run_done", done_o, 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
